// File: rtl/logic_unit_seq.sv
// Registered bitwise logic unit with valid/ready streaming and an OR-fold
// accumulate mode that merges a multi-beat group into a single result.
module logic_unit_seq #(
   parameter int WIDTH   = 32,
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         op,
   input  logic               acc_mode,
   input  logic               acc_last,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic               zero,
   output logic [COUNT_W-1:0] beats,
   output logic [1:0]         fsm_state
);

   // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
   // a result transfers where out_valid && out_ready. in_ready is a function
   // of state and out_ready only, so valid never loops back into ready.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

   state_t             state;
   state_t             state_next;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   acc_next;
   logic [COUNT_W-1:0] cnt;
   logic [COUNT_W-1:0] cnt_next;
   logic [WIDTH-1:0]   result_next;
   logic [COUNT_W-1:0] beats_next;
   logic               load;
   logic [WIDTH-1:0]   r;
   logic               accept;

   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
      return (c == '1) ? c : c + ONE;
   endfunction

   always_comb begin
      r = '0;
      unique case (op)
         3'b000: r = a & b;
         3'b001: r = a | b;
         3'b010: r = a ^ b;
         3'b011: r = ~(a | b);
         3'b100: r = ~(a & b);
         3'b101: r = ~(a ^ b);
         3'b110: r = a & ~b;
         3'b111: r = a | ~b;
         default: r = '0;
      endcase
   end

   assign in_ready  = (state != HOLD) || out_ready;
   assign out_valid = (state == HOLD);
   assign accept    = in_valid && in_ready;
   assign fsm_state = state;

   always_comb begin
      state_next  = state;
      acc_next    = acc;
      cnt_next    = cnt;
      result_next = result;
      beats_next  = beats;
      load        = 1'b0;
      unique case (state)
         IDLE, HOLD: begin
            if (accept) begin
               if (!acc_mode || acc_last) begin
                  load        = 1'b1;
                  result_next = r;
                  beats_next  = ONE;
                  state_next  = HOLD;
               end else begin
                  acc_next   = r;
                  cnt_next   = ONE;
                  state_next = ACCUM;
               end
            end else if (state == HOLD && out_ready) begin
               state_next = IDLE;
            end
         end
         ACCUM: begin
            // acc_mode is ignored once a group is open; only acc_last matters.
            if (accept) begin
               if (acc_last) begin
                  load        = 1'b1;
                  result_next = acc | r;
                  beats_next  = sat_inc(cnt);
                  state_next  = HOLD;
               end else begin
                  acc_next = acc | r;
                  cnt_next = sat_inc(cnt);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         acc    <= '0;
         cnt    <= '0;
         result <= '0;
         zero   <= 1'b1;
         beats  <= '0;
      end else begin
         state <= state_next;
         acc   <= acc_next;
         cnt   <= cnt_next;
         if (load) begin
            result <= result_next;
            zero   <= (result_next == '0);
            beats  <= beats_next;
         end
      end
   end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Bench for logic_unit_seq: directed scenarios plus random traffic, checked by
// a group-level reference model feeding an expected-result queue.
module tb_logic_unit_seq;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        out_ready;
   logic [2:0]  op;
   logic        acc_mode;
   logic        acc_last;
   logic [31:0] a;
   logic [31:0] b;

   logic        in_ready, out_valid, zero;
   logic [31:0] result;
   logic [7:0]  beats;
   logic [1:0]  fsm_state;

   logic        in_ready2, out_valid2, zero2;
   logic [31:0] result2;
   logic [1:0]  beats2;
   logic [1:0]  fsm_state2;

   logic_unit_seq #(.WIDTH(32), .COUNT_W(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .acc_mode(acc_mode), .acc_last(acc_last), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .zero(zero), .beats(beats), .fsm_state(fsm_state)
   );

   // Narrow-counter instance sharing the same stimulus, for saturation.
   logic_unit_seq #(.WIDTH(32), .COUNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
      .op(op), .acc_mode(acc_mode), .acc_last(acc_last), .a(a), .b(b),
      .out_valid(out_valid2), .out_ready(out_ready), .result(result2),
      .zero(zero2), .beats(beats2), .fsm_state(fsm_state2)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // expected entry: {result[41:10], beats8[9:2], beats2[1:0]}
   logic [41:0] exp_q[$];

   // reference model state: whole groups, not FSM states
   bit          pending;
   bit          in_group;
   logic [31:0] grp_or;
   int          grp_n;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_op(input logic [2:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
      logic [31:0] v;
      case (o)
         3'd0: v = x & y;
         3'd1: v = x | y;
         3'd2: v = x ^ y;
         3'd3: v = ~(x | y);
         3'd4: v = ~(x & y);
         3'd5: v = ~(x ^ y);
         3'd6: v = x & ~y;
         default: v = x | ~y;
      endcase
      return v;
   endfunction

   task automatic push_group(input logic [31:0] val, input int n);
      logic [7:0] s8;
      logic [1:0] s2;
      s8 = (n > 255) ? 8'd255 : 8'(n);
      s2 = (n > 3) ? 2'd3 : 2'(n);
      exp_q.push_back({val, s8, s2});
   endtask

   task automatic model_clear();
      pending  = 0;
      in_group = 0;
      grp_or   = '0;
      grp_n    = 0;
      exp_q.delete();
   endtask

   // driver: one cycle of stimulus, then advance the model at the edge
   task automatic step(input bit iv, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input bit am, input bit al, input bit rdy);
      bit          exp_rdy, closed, fired;
      logic [31:0] r;
      @(negedge clk);
      in_valid = iv; op = o; a = x; b = y; acc_mode = am; acc_last = al; out_ready = rdy;
      exp_rdy = !pending || rdy;
      #1;
      check("in_ready", in_ready, exp_rdy);
      check("in_ready_sat", in_ready2, exp_rdy);
      @(posedge clk);
      closed = 0;
      fired  = pending && rdy;
      if (iv && exp_rdy) begin
         r = model_op(o, x, y);
         if (in_group) begin
            grp_or = grp_or | r;
            grp_n++;
            if (al) begin
               push_group(grp_or, grp_n);
               in_group = 0;
               closed   = 1;
            end
         end else if (!am || al) begin
            push_group(r, 1);
            closed = 1;
         end else begin
            in_group = 1;
            grp_or   = r;
            grp_n    = 1;
         end
      end
      pending = closed ? 1 : (fired ? 0 : pending);
   endtask

   task automatic expect_out(input string nm, input logic [31:0] res, input logic [7:0] bt);
      #2;
      check({nm, "_valid"}, out_valid, 1);
      check({nm, "_result"}, result, res);
      check({nm, "_zero"}, zero, res == 0);
      check({nm, "_beats"}, beats, bt);
   endtask

   task automatic check_reset_values(input string nm);
      check({nm, "_out_valid"}, out_valid, 0);
      check({nm, "_result"}, result, 0);
      check({nm, "_zero"}, zero, 1);
      check({nm, "_beats"}, beats, 0);
      check({nm, "_beats_sat"}, beats2, 0);
   endtask

   // monitor: compares whatever the DUT presents with the queue head
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!reset) begin
            check("out_valid", out_valid, exp_q.size() != 0);
            check("out_valid_sat", out_valid2, exp_q.size() != 0);
            if (out_valid && exp_q.size() != 0) begin
               check("sb_result", result, exp_q[0][41:10]);
               check("sb_zero", zero, exp_q[0][41:10] == 0);
               check("sb_beats", beats, exp_q[0][9:2]);
               check("sb_result_sat", result2, exp_q[0][41:10]);
               check("sb_beats_sat", beats2, exp_q[0][1:0]);
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   logic [31:0] op_tbl [8];

   initial begin
      op_tbl = '{32'hFF00_0000, 32'hFFFF_FF00, 32'h00FF_FF00, 32'h0000_00FF,
                 32'h00FF_FFFF, 32'hFF00_00FF, 32'h00FF_0000, 32'hFFFF_00FF};
      reset = 1'b1; in_valid = 0; out_ready = 0; op = 0; acc_mode = 0; acc_last = 0;
      a = 0; b = 0;
      model_clear();
      repeat (2) @(negedge clk);
      #1;
      check_reset_values("reset");
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset_in_ready", in_ready, 1);

      // direct OR
      step(1, 3'b001, 32'hF0F0_0000, 32'h0000_0F0F, 0, 0, 1);
      expect_out("direct_or", 32'hF0F0_0F0F, 8'd1);

      // all eight ops back to back
      for (int i = 0; i < 8; i++) begin
         step(1, 3'(i), 32'hFFFF_0000, 32'hFF00_FF00, 0, 0, 1);
         expect_out($sformatf("op%0d", i), op_tbl[i], 8'd1);
      end

      // 3-beat XOR accumulate
      step(1, 3'b010, 32'h1, 32'h0, 1, 0, 1);
      #2 check("acc_beat1_quiet", out_valid, 0);
      step(1, 3'b010, 32'h4, 32'h0, 1, 0, 1);
      #2 check("acc_beat2_quiet", out_valid, 0);
      step(1, 3'b010, 32'h0, 32'h10, 1, 1, 1);
      expect_out("acc3", 32'h15, 8'd3);

      // backpressure, then same-edge handoff
      step(1, 3'b001, 32'h5, 32'h0, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         step(1, 3'($urandom_range(0, 7)), $urandom, $urandom, 0, 0, 0);
         expect_out("bp_hold", 32'h5, 8'd1);
      end
      step(1, 3'b000, 32'h0, 32'h0, 0, 0, 1);
      expect_out("bp_handoff", 32'h0, 8'd1);

      // 6-beat group: wide counter reads 6, 2-bit counter saturates at 3
      for (int i = 0; i < 6; i++)
         step(1, 3'b001, 32'(1) << i, 32'h0, 1, i == 5, 1);
      expect_out("sat6", 32'h3F, 8'd6);
      check("sat6_beats_sat", beats2, 2'd3);

      // reset mid-group discards it
      step(1, 3'b001, 32'h3, 32'h0, 1, 0, 1);
      step(1, 3'b001, 32'hC, 32'h0, 0, 0, 1);
      @(negedge clk);
      in_valid = 0;
      reset    = 1'b1;
      model_clear();
      #1;
      check_reset_values("mid_reset");
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid_reset_in_ready", in_ready, 1);
      step(1, 3'b010, 32'hA0, 32'h0A, 0, 0, 1);
      expect_out("post_reset", 32'hAA, 8'd1);

      // random traffic
      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
              ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
              ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
              $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3,
              $urandom_range(0, 9) < 7);

      // drain
      for (int i = 0; i < 3; i++) step(0, 3'b000, 32'h0, 32'h0, 0, 0, 1);
      check("drain_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
